food_spawn_controller: RTL
==========================

Name: food_spawn_controller

Overview:
Sequences placement of a new food item on the snake grid. It draws candidate cells from a 12-bit LFSR seeded by the random seed generator, and checks each candidate against the snake-body occupancy store through a req/ack lookup port. It retries up to a limit, then falls back to a linear scan, and reports either a free cell or a full grid. It sits between the seed generator, the occupancy store and the game FSM, which issues spawn requests.

Parameters:
GRID_W, 32, grid columns; GRID_W <= 2^X_W and 2*GRID_W >= 2^X_W
GRID_H, 24, grid rows; same constraint against Y_W
X_W, 5, column coordinate width
Y_W, 5, row coordinate width
MAX_TRIES, 16, random attempts before the scan fallback (1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
seed  in  12  seed value from the seed generator
seed_load  in  1  pulse; loads seed into the LFSR (honoured in IDLE only)
spawn_req  in  1  pulse; start placement (honoured in IDLE only)
busy  out  1  high in every non-IDLE state
food_x  out  X_W  placed column
food_y  out  Y_W  placed row
food_valid  out  1  level; food_x/food_y valid; held until the next accepted spawn_req
grid_full  out  1  level; no free cell found; held until the next accepted spawn_req
occ_req  out  1  occupancy lookup request
occ_x  out  X_W  lookup column, stable while occ_req=1
occ_y  out  Y_W  lookup row, stable while occ_req=1
occ_ack  in  1  lookup done; may assert in the same cycle as occ_req
occ_hit  in  1  cell occupied; sampled only when occ_req&occ_ack

Behaviour:
- Reset (async, immediate): busy=0, food_x=0, food_y=0, food_valid=0, grid_full=0, occ_req=0, occ_x=0, occ_y=0, LFSR=12'hDCF, state=IDLE, tries=0.
- LFSR: Fibonacci, fb = l[11]^l[5]^l[3]^l[0], next = {l[10:0],fb}. Steps only on GEN entry. Loading 0 forces 12'hDCF.
- Candidate mapping: raw_x=l[X_W-1:0], raw_y=l[X_W+Y_W-1:X_W]. If raw >= GRID, subtract GRID.
- IDLE:
  - seed_load loads the LFSR.
  - spawn_req clears food_valid and grid_full, sets tries=0, and moves to GEN.
  - Both in the same cycle: the load takes effect and GEN steps from the loaded seed.
- GEN (1 cycle): step the LFSR, register the mapped candidate into occ_x/occ_y, tries++, then go to QUERY.
- QUERY: occ_req=1 until occ_ack.
  - On ack with !hit: latch food=candidate, food_valid=1, go to IDLE.
  - On ack with hit and tries<MAX_TRIES: go to GEN.
  - On ack with hit and tries==MAX_TRIES: go to SCAN with cell=next(candidate) and scan_cnt=0.
- next(x,y): x+1; at x==GRID_W-1, x=0 and y+1; at y==GRID_H-1 also y wraps to 0.
- SCAN: occ_req=1 on the current cell.
  - On ack with !hit: latch food, food_valid=1, go to IDLE.
  - On ack with hit and scan_cnt==GRID_W*GRID_H-1: grid_full=1, food_valid=0, go to IDLE.
  - Otherwise: scan_cnt++, cell=next, occ_req drops for 1 cycle, stay in SCAN.
- Latency, first-try free cell, zero-wait ack: spawn_req sampled at edge 0; GEN at edge 1; food_valid high after edge 2.
- spawn_req or seed_load while busy: ignored, no queueing.
- occ_ack without occ_req: ignored.
- occ_req never drops before ack. occ_x/occ_y change only while occ_req=0 or on the ack edge.
- Reset mid-lookup: occ_req drops asynchronously and the next lookup restarts from the reset state.
- scan_cnt width is clog2(GRID_W*GRID_H); tries width is 8 bits.

Decomposition:
- Shared package snake_pkg holds:
  - GRID_W, GRID_H, X_W, Y_W
  - SEED_DEFAULT=12'hDCF
  - LFSR tap constants
  - state enum {IDLE, GEN, QUERY, SCAN}
- One sub-module, spawn_lfsr: 12-bit LFSR with load, step, zero-seed substitution and reset to SEED_DEFAULT.

Test Plan:
- Reset, then seed_load 12'h001, spawn_req, ack same cycle with hit=0 -> occ_x=3, occ_y=0; food=(3,0); food_valid high 3 edges after spawn_req; busy then 0.
- Seed 12'h001, first lookup hit=1, second hit=0 -> second query at (7,0); food=(7,0); tries=2.
- Occupancy model with all cells occupied except (5,10), MAX_TRIES=16 -> 16 random queries, then scan reaches (5,10); food=(5,10); grid_full=0.
- All cells occupied -> 16 + 768 acked queries; grid_full=1, food_valid=0, busy falls; next spawn_req clears grid_full.
- Ack delayed 4 cycles, spawn_req and seed_load pulsed during QUERY -> occ_req/occ_x/occ_y stable until ack; the pulses are ignored; LFSR unchanged.
- rst low during QUERY -> occ_req=0 immediately, all outputs at reset values; after release, spawn with zero-wait ack and hit=0 gives the candidate from 12'hDCF stepped once.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game blocks.
// Grid geometry, LFSR seed/taps and the food spawn state encoding.
package snake_pkg;

  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  localparam int X_W    = 5;
  localparam int Y_W    = 5;

  localparam int LFSR_W = 12;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 12'hDCF;

  localparam int TAP_A = 11;
  localparam int TAP_B = 5;
  localparam int TAP_C = 3;
  localparam int TAP_D = 0;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    QUERY,
    SCAN
  } spawn_state_t;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] l);
    return l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D];
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 12-bit Fibonacci LFSR for food candidates.
// A zero seed would lock the register, so it is replaced by the default.
module spawn_lfsr
  import snake_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] nxt
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] seed_fix;

  assign seed_fix = (seed == '0) ? SEED_DEFAULT : seed;
  assign nxt      = {lfsr[LFSR_W-2:0], lfsr_fb(lfsr)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED_DEFAULT;
    end else if (load) begin
      lfsr <= seed_fix;
    end else if (step) begin
      lfsr <= nxt;
    end
  end

endmodule

// File: rtl/food_spawn_controller.sv
// Food placement: random candidates checked against the occupancy
// store, then a linear scan fallback that can report a full grid.
module food_spawn_controller #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int X_W       = 5,
  parameter int Y_W       = 5,
  parameter int MAX_TRIES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [11:0]    seed,
  input  logic           seed_load,
  input  logic           spawn_req,
  output logic           busy,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           food_valid,
  output logic           grid_full,
  output logic           occ_req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  input  logic           occ_ack,
  input  logic           occ_hit
);

  import snake_pkg::*;

  localparam int CELLS = GRID_W * GRID_H;
  localparam int SC_W  = $clog2(CELLS);

  spawn_state_t      state;
  logic [7:0]        tries;
  logic [SC_W-1:0]   scan_cnt;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              lfsr_unused;
  logic [X_W-1:0]    raw_x;
  logic [X_W-1:0]    cand_x;
  logic [X_W-1:0]    nx;
  logic [Y_W-1:0]    raw_y;
  logic [Y_W-1:0]    cand_y;
  logic [Y_W-1:0]    ny;
  logic              last_x;
  logic              last_y;

  assign lfsr_load = (state == IDLE) && seed_load;
  assign lfsr_step = (state == GEN);

  spawn_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .seed (seed),
    .nxt  (lfsr_nxt)
  );

  assign lfsr_unused = ^lfsr_nxt[LFSR_W-1:X_W+Y_W];

  // Coordinate fields can exceed the grid by less than one grid width.
  assign raw_x  = lfsr_nxt[X_W-1:0];
  assign raw_y  = lfsr_nxt[X_W+Y_W-1:X_W];
  assign cand_x = ({1'b0, raw_x} >= (X_W+1)'(GRID_W))
                ? raw_x - X_W'(GRID_W) : raw_x;
  assign cand_y = ({1'b0, raw_y} >= (Y_W+1)'(GRID_H))
                ? raw_y - Y_W'(GRID_H) : raw_y;

  assign last_x = (occ_x == X_W'(GRID_W - 1));
  assign last_y = (occ_y == Y_W'(GRID_H - 1));
  assign nx     = last_x ? '0 : occ_x + X_W'(1);
  assign ny     = !last_x ? occ_y
                : (last_y ? '0 : occ_y + Y_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tries      <= '0;
      scan_cnt   <= '0;
      busy       <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      grid_full  <= 1'b0;
      occ_req    <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (spawn_req) begin
            food_valid <= 1'b0;
            grid_full  <= 1'b0;
            tries      <= '0;
            busy       <= 1'b1;
            state      <= GEN;
          end
        end
        GEN: begin
          occ_x   <= cand_x;
          occ_y   <= cand_y;
          tries   <= tries + 8'd1;
          occ_req <= 1'b1;
          state   <= QUERY;
        end
        QUERY: begin
          if (occ_ack) begin
            occ_req <= 1'b0;
            if (!occ_hit) begin
              food_x     <= occ_x;
              food_y     <= occ_y;
              food_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else if (tries < 8'(MAX_TRIES)) begin
              state <= GEN;
            end else begin
              occ_x    <= nx;
              occ_y    <= ny;
              scan_cnt <= '0;
              state    <= SCAN;
            end
          end
        end
        SCAN: begin
          // Request is re-raised one cycle after each cell move.
          if (!occ_req) begin
            occ_req <= 1'b1;
          end else if (occ_ack) begin
            occ_req <= 1'b0;
            if (!occ_hit) begin
              food_x     <= occ_x;
              food_y     <= occ_y;
              food_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else if (scan_cnt == SC_W'(CELLS - 1)) begin
              grid_full  <= 1'b1;
              food_valid <= 1'b0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              scan_cnt <= scan_cnt + SC_W'(1);
              occ_x    <= nx;
              occ_y    <= ny;
            end
          end
        end
      endcase
    end
  end

endmodule
